// File: rtl/axilite_csr_write_slave.sv
// rtl/axilite_csr_write_slave.sv - AXI-Lite write-only CSR bank with byte strobes and SLVERR decode
// Optional read-only register protection is enabled by defining AXILITE_CSR_RO_MASK_EN.
module axilite_csr_write_slave #(
  parameter int                             NUM_REGS    = 4,
  parameter int                             DATA_WIDTH  = 32,
  parameter int                             ADDR_SIZE   = 32,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [1:0]                     RESP_OKAY   = 2'd0,
  parameter logic [1:0]                     RESP_EXOKAY = 2'd1,
  parameter logic [1:0]                     RESP_SLVERR = 2'd2,
  parameter logic [1:0]                     RESP_DECERR = 2'd3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_SIZE-1:0]           awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HAVE_AW = 3'd1,
    HAVE_W  = 3'd2,
    COMMIT  = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic                           awready_q, awready_d;
  logic                           wready_q, wready_d;
  logic                           bvalid_q, bvalid_d;
  logic [1:0]                     bresp_q, bresp_d;
  logic [ADDR_SIZE-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [STRB_W-1:0]              wstrb_q, wstrb_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;

  logic                           aw_hs, w_hs;
  logic [ADDR_SIZE-1:0]           idx;
  logic                           in_range, ro_hit;
  logic [NUM_REGS-1:0]            sel;
  logic                           unused_params;

  assign aw_hs    = awvalid && awready_q;
  assign w_hs     = wvalid && wready_q;
  // Full-width compare so high address bits can never alias onto a low register.
  assign idx      = addr_q >> ADDR_LSB;
  assign in_range = idx < ADDR_SIZE'(NUM_REGS);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = in_range && (idx == ADDR_SIZE'(i));
    end
  end

`ifdef AXILITE_CSR_RO_MASK_EN
  assign ro_hit        = |(sel & RO_MASK);
  assign unused_params = ^{RESP_EXOKAY, RESP_DECERR};
`else
  assign ro_hit        = 1'b0;
  assign unused_params = ^{RESP_EXOKAY, RESP_DECERR, RO_MASK};
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (aw_hs) addr_d = awaddr;
    if (w_hs) begin
      wdata_d = wdata;
      wstrb_d = wstrb;
    end

    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = COMMIT;
        else if (aw_hs)    state_d = HAVE_AW;
        else if (w_hs)     state_d = HAVE_W;
      end
      HAVE_AW: if (w_hs)  state_d = COMMIT;
      HAVE_W:  if (aw_hs) state_d = COMMIT;
      COMMIT: begin
        state_d  = RESP;
        bvalid_d = 1'b1;
        if (in_range && !ro_hit) begin
          bresp_d = RESP_OKAY;
          for (int i = 0; i < NUM_REGS; i++) begin
            for (int k = 0; k < STRB_W; k++) begin
              if (sel[i] && wstrb_q[k]) begin
                regs_d[i*DATA_WIDTH + k*8 +: 8] = wdata_q[k*8 +: 8];
              end
            end
          end
          wr_pulse_d = (|wstrb_q) ? sel : '0;
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      RESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Readies follow the next state so they are pure flops with no path from the valids.
    awready_d = (state_d == IDLE) || (state_d == HAVE_W);
    wready_d  = (state_d == IDLE) || (state_d == HAVE_AW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      regs_q     <= RESET_VALUE;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign regs     = regs_q;
  assign wr_pulse = wr_pulse_q;
endmodule

// File: tb/tb_axilite_csr_write_slave.sv
// tb/tb_axilite_csr_write_slave.sv - directed bench with a transaction-level CSR model for axilite_csr_write_slave
module tb_axilite_csr_write_slave;
  localparam logic [127:0] RV = {32'h33333333, 32'hAAAAAAAA, 32'h11111111, 32'h5A5A0000};
  localparam logic [3:0]   RO_MASK_TB = 4'b0001;
`ifdef AXILITE_CSR_RO_MASK_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [127:0] regs;
  logic [3:0]   wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  axilite_csr_write_slave #(
    .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_SIZE(32),
    .RESET_VALUE(RV), .RO_MASK(RO_MASK_TB)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .regs(regs), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks which halves of a write are held and whether a response is owed.
  logic [31:0] mregs [4];
  bit          m_have_a, m_have_w, m_commit, m_bvalid, m_awready, m_wready;
  logic [31:0] m_addr, m_data, m_idx;
  logic [3:0]  m_strb, m_pulse;
  logic [1:0]  m_bresp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mregs[i] = RV[i*32 +: 32];
      m_have_a = 0; m_have_w = 0; m_commit = 0; m_bvalid = 0;
      m_awready = 0; m_wready = 0; m_pulse = '0; m_bresp = 2'd0;
      m_addr = '0; m_data = '0; m_strb = '0;
    end else begin
      m_pulse = '0;
      if (m_bvalid) begin
        if (bready) m_bvalid = 0;
      end else if (m_commit) begin
        m_commit = 0;
        m_bvalid = 1;
        m_idx = m_addr / 4;
        if (m_idx < 4 && !(RO_EN && RO_MASK_TB[m_idx[1:0]])) begin
          for (int k = 0; k < 4; k++)
            if (m_strb[k]) mregs[m_idx[1:0]][k*8 +: 8] = m_data[k*8 +: 8];
          if (m_strb != 0) m_pulse[m_idx[1:0]] = 1'b1;
          m_bresp = 2'd0;
        end else begin
          m_bresp = 2'd2;
        end
      end else begin
        if (awvalid && m_awready) begin m_have_a = 1; m_addr = awaddr; end
        if (wvalid && m_wready) begin m_have_w = 1; m_data = wdata; m_strb = wstrb; end
        if (m_have_a && m_have_w) begin m_commit = 1; m_have_a = 0; m_have_w = 0; end
      end
      m_awready = !m_commit && !m_bvalid && !m_have_a;
      m_wready  = !m_commit && !m_bvalid && !m_have_w;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("awready", awready, m_awready);
      chk("wready", wready, m_wready);
      chk("bvalid", bvalid, m_bvalid);
      chk("wr_pulse", wr_pulse, m_pulse);
      chk("regs", regs, {mregs[3], mregs[2], mregs[1], mregs[0]});
      if (m_bvalid || !rst) chk("bresp", bresp, m_bresp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
  endtask

  int cnt;

  initial begin
    @(posedge clk);
    mon_en = 1;
    #1;
    chk("rst_regs", regs, RV);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'd0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wr_pulse", wr_pulse, 4'b0);
    tick();
    rst = 1;
    #1 chk("deassert_awready_low", awready, 1'b0);
    tick();
    chk("deassert_awready_high", awready, 1'b1);
    chk("deassert_wready_high", wready, 1'b1);

    // Same-cycle AW/W to reg1
    bready = 1;
    send_both(32'h4, 32'hDEADBEEF, 4'hF);
    chk("same_cycle_bvalid_early", bvalid, 1'b0);
    tick();
    chk("same_cycle_reg1", regs[63:32], 32'hDEADBEEF);
    chk("same_cycle_pulse", wr_pulse, 4'b0010);
    chk("same_cycle_bvalid", bvalid, 1'b1);
    chk("same_cycle_bresp", bresp, 2'd0);
    tick();
    chk("same_cycle_pulse_gone", wr_pulse, 4'b0000);
    chk("same_cycle_idle_awready", awready, 1'b1);

    // W first, AW three cycles later, partial strobes
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1;
    tick();
    wvalid = 0;
    tick(); tick();
    awaddr = 32'h8; awvalid = 1;
    tick();
    awvalid = 0;
    tick();
    chk("w_first_reg2", regs[95:64], 32'hAA22AA44);
    chk("w_first_bresp", bresp, 2'd0);
    tick();

    // AW first, W later, lanes 1 and 3
    awaddr = 32'hC; awvalid = 1;
    tick();
    awvalid = 0;
    tick();
    wdata = 32'hCAFEF00D; wstrb = 4'hA; wvalid = 1;
    tick();
    wvalid = 0;
    tick();
    chk("aw_first_reg3", regs[127:96], 32'hCA33F033);
    tick();

    // Zero strobe, in range
    send_both(32'h0, 32'hFFFFFFFF, 4'h0);
    tick();
    chk("zero_strb_bresp", bresp, 2'd0);
    chk("zero_strb_pulse", wr_pulse, 4'b0);
    chk("zero_strb_reg0", regs[31:0], 32'h5A5A0000);
    tick();

    // Out of range and high-bit alias attempt
    send_both(32'h10, 32'hFFFFFFFF, 4'hF);
    tick();
    chk("oor_bresp", bresp, 2'd2);
    chk("oor_pulse", wr_pulse, 4'b0);
    chk("oor_regs", regs, {32'hCA33F033, 32'hAA22AA44, 32'hDEADBEEF, 32'h5A5A0000});
    tick();
    send_both(32'h80000004, 32'h0, 4'hF);
    tick();
    chk("alias_bresp", bresp, 2'd2);
    chk("alias_reg1", regs[63:32], 32'hDEADBEEF);
    tick();

    // Unaligned address selects the containing word
    send_both(32'h7, 32'h01020304, 4'h1);
    tick();
    chk("unaligned_reg1", regs[63:32], 32'hDEADBE04);
    tick();

    // Write to reg0, protected only in the read-only build
    send_both(32'h0, 32'h12345678, 4'hF);
    tick();
    chk("ro_bresp", bresp, RO_EN ? 2'd2 : 2'd0);
    chk("ro_reg0", regs[31:0], RO_EN ? 32'h5A5A0000 : 32'h12345678);
    chk("ro_pulse", wr_pulse, RO_EN ? 4'b0000 : 4'b0001);
    tick();

    // Response stall with bready low
    bready = 0;
    send_both(32'h8, 32'h0000FFFF, 4'h3);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", bvalid, 1'b1);
      chk("stall_bresp", bresp, 2'd0);
      chk("stall_awready", awready, 1'b0);
      chk("stall_wready", wready, 1'b0);
      tick();
    end
    bready = 1;
    tick();
    chk("stall_release_bvalid", bvalid, 1'b0);
    chk("stall_release_awready", awready, 1'b1);
    chk("stall_reg2", regs[95:64], 32'hAA22FFFF);

    // Back-to-back throughput with valids held high
    awaddr = 32'hC; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (awready) cnt++;
      tick();
    end
    awvalid = 0; wvalid = 0;
    chk("throughput_3_in_9", cnt, 3);
    tick();

    // Reset while holding an address
    awaddr = 32'h4; awvalid = 1;
    tick();
    awvalid = 0;
    #2 rst = 0;
    #1;
    chk("midrst_regs", regs, RV);
    chk("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_awready", awready, 1'b0);
    tick(); tick();
    rst = 1;
    tick();
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid) cnt++;
      tick();
    end
    chk("midrst_no_response", cnt, 0);
    chk("midrst_regs_after", regs, RV);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
